// File: rtl/vending_pkg.sv
// Shared vending definitions: coin codes, acceptor states
// and the saturating rupee adder.
package vending_pkg;

  localparam logic [1:0] RUPEE_0 = 2'b00;
  localparam logic [1:0] RUPEE_1 = 2'b01;
  localparam logic [1:0] RUPEE_2 = 2'b10;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_DEBOUNCE,
    ACC_WAIT_RELEASE,
    ACC_JAM
  } acc_state_t;

  function automatic logic [7:0] sat_add(
    input logic [7:0] total,
    input logic [1:0] code
  );
    logic [8:0] sum;
    sum = {1'b0, total} + {7'b0, code};
    return sum[8] ? 8'hff : sum[7:0];
  endfunction

endpackage

// File: rtl/coin_sync_debounce_bit.sv
// Two-flop synchroniser for one raw coin-chute sensor.
// Debounce timing is handled by the acceptor FSM.
module coin_sync_debounce_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: synchronise, debounce, jam detect and
// emit one registered coin code per accepted coin.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_HOLD_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense_r1,
  input  logic       sense_r2,
  input  logic       vend_busy,
  output logic [1:0] coin_code,
  output logic       coin_reject,
  output logic       jam,
  output logic [7:0] rupee_total
);

  localparam int CW = $clog2(MAX_HOLD_CYCLES + 1);
  localparam logic [CW-1:0] DB    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_M1 = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] MH    = CW'(MAX_HOLD_CYCLES);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic s1, s2;

  coin_sync_debounce_bit u_sync_r1 (
    .clk (clk),
    .rst (rst),
    .d   (sense_r1),
    .q   (s1)
  );

  coin_sync_debounce_bit u_sync_r2 (
    .clk (clk),
    .rst (rst),
    .d   (sense_r2),
    .q   (s2)
  );

  acc_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] hold, hold_n;
  logic          kind, kind_n;
  logic [1:0]    code_n;
  logic          rej_n;
  logic [7:0]    total_n;

  logic lat, oth, both_low;

  // kind selects the latched chute: 0 = 1-rupee, 1 = 2-rupee
  assign lat      = kind ? s2 : s1;
  assign oth      = kind ? s1 : s2;
  assign both_low = !s1 && !s2;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hold_n  = hold;
    kind_n  = kind;
    code_n  = RUPEE_0;
    rej_n   = 1'b0;
    total_n = rupee_total;
    unique case (state)
      ACC_IDLE: begin
        unique case (1'b1)
          (s1 && s2): begin
            state_n = ACC_JAM;
            cnt_n   = '0;
          end
          (s1 ^ s2): begin
            state_n = ACC_DEBOUNCE;
            kind_n  = s2;
            cnt_n   = '0;
          end
          default: ;
        endcase
      end
      ACC_DEBOUNCE: begin
        if (oth) begin
          state_n = ACC_JAM;
          cnt_n   = '0;
        end else if (!lat) begin
          state_n = ACC_IDLE;
          cnt_n   = '0;
        end else if (cnt == DB) begin
          state_n = ACC_WAIT_RELEASE;
          cnt_n   = '0;
          hold_n  = '0;
          if (vend_busy) begin
            rej_n = 1'b1;
          end else begin
            code_n  = kind ? RUPEE_2 : RUPEE_1;
            total_n = sat_add(rupee_total, code_n);
          end
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      ACC_WAIT_RELEASE: begin
        hold_n = hold + ONE;
        cnt_n  = both_low ? cnt + ONE : '0;
        if (both_low && cnt == DB_M1) begin
          state_n = ACC_IDLE;
          cnt_n   = '0;
        end else if (hold == MH) begin
          state_n = ACC_JAM;
          cnt_n   = '0;
        end
      end
      ACC_JAM: begin
        cnt_n = both_low ? cnt + ONE : '0;
        if (both_low && cnt == DB_M1) begin
          state_n = ACC_IDLE;
          cnt_n   = '0;
          rej_n   = 1'b1;
        end
      end
      default: state_n = ACC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACC_IDLE;
      cnt         <= '0;
      hold        <= '0;
      kind        <= 1'b0;
      coin_code   <= RUPEE_0;
      coin_reject <= 1'b0;
      rupee_total <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      hold        <= hold_n;
      kind        <= kind_n;
      coin_code   <= code_n;
      coin_reject <= rej_n;
      rupee_total <= total_n;
    end
  end

  assign jam = (state == ACC_JAM);

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage for the vending FSM. Samples two raw coin-slot sensors (1-rupee and 2-rupee chutes).
- Synchronises and debounces both sensors, and detects jams and double-drops.
- For each valid coin, emits exactly one single-cycle 2-bit coin code that drives the vending FSM's coin_in input directly.
- Coins that arrive while the vending FSM is dispensing are rejected, never forwarded.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles needed to accept a coin or a release. Legal range 2..255.
- MAX_HOLD_CYCLES, 64: maximum cycles a sensor may stay high after acceptance before a jam is declared. Legal range 4..1023. Must exceed DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sense_r1  in  1  raw 1-rupee chute sensor, asynchronous, high = coin present
- sense_r2  in  1  raw 2-rupee chute sensor, asynchronous, high = coin present
- vend_busy  in  1  dispensing indication, tied to the vending FSM product_out
- coin_code  out  2  00 none, 01 one rupee, 10 two rupees, 11 never driven; single-cycle pulse
- coin_reject  out  1  single-cycle pulse: coin diverted to the return chute
- jam  out  1  level, high while in the JAM state
- rupee_total  out  8  saturating count of accepted rupees since reset

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: sync flops 0, state IDLE, counters 0, coin_code 00, coin_reject 0, jam 0, rupee_total 0. Reset mid-operation abandons any coin in progress with no pulse.
- Synchronisers: two-flop synchroniser per sensor, giving s1 and s2. All state logic uses s1/s2 only.
- States: IDLE, DEBOUNCE, WAIT_RELEASE, JAM.
- IDLE:
  - exactly one of s1/s2 high: latch the coin type, clear cnt, go to DEBOUNCE.
  - both high: go to JAM.
  - neither high: stay.
- DEBOUNCE:
  - latched sensor high and other sensor low: increment cnt.
  - cnt reaches DEBOUNCE_CYCLES: accept the coin and go to WAIT_RELEASE with cnt cleared.
  - latched sensor low before acceptance: glitch. Return to IDLE with no output.
  - other sensor high: go to JAM.
- Acceptance (one cycle, registered output):
  - vend_busy low: coin_code = latched type for exactly one cycle. rupee_total += 1 or 2, saturating at 255 (never wraps).
  - vend_busy high: coin_reject = 1 for one cycle, coin_code stays 00, rupee_total unchanged.
- Latency: raw sensor held high from the sampling edge at cycle 0 gives the coin_code pulse in cycle DEBOUNCE_CYCLES+3, i.e. cycle 7 at default.
- WAIT_RELEASE:
  - both s1/s2 low for DEBOUNCE_CYCLES consecutive cycles: go to IDLE. Any high sample restarts the low count.
  - total time in this state exceeds MAX_HOLD_CYCLES: go to JAM.
  - new sensor activity here never produces a second code.
- JAM:
  - jam = 1.
  - exit when both s1/s2 have been low for DEBOUNCE_CYCLES consecutive cycles: coin_reject pulses for one cycle on the exit transition, then IDLE.
  - no coin_code is ever issued for a jammed or double-dropped coin.
- Output invariants:
  - coin_code and coin_reject are never active in the same cycle.
  - At most one nonzero coin_code per physical coin.
  - Consecutive coin_code pulses are separated by at least DEBOUNCE_CYCLES+1 cycles.
- Width rules:
  - cnt is sized to $clog2(MAX_HOLD_CYCLES+1).
  - rupee_total addition uses a 9-bit intermediate, then clamps to 255.

Decomposition:
- Shared package vending_pkg:
  - coin code constants RUPEE_0 = 2'b00, RUPEE_1 = 2'b01, RUPEE_2 = 2'b10.
  - acceptor state encoding, also used by the vending FSM for its coin decode.
- One sub-module: coin_sync_debounce_bit, the two-flop synchroniser. Instantiated twice, for sense_r1 and sense_r2.
- The FSM and counters stay in coin_acceptor.

Test Plan (all at DEBOUNCE_CYCLES = 4, MAX_HOLD_CYCLES = 64):
- Clean 1-rupee coin:
  - Stimulus: sense_r1 high for 20 cycles, vend_busy = 0.
  - Required: coin_code = 01 for exactly one cycle at cycle 7; rupee_total = 1; then IDLE 4 cycles after s1 falls.
- Glitch:
  - Stimulus: sense_r2 high for 3 cycles only.
  - Required: no coin_code, no coin_reject; rupee_total stays 0; state returns to IDLE.
- Busy reject:
  - Stimulus: sense_r2 held 20 cycles with vend_busy = 1.
  - Required: coin_reject pulses once at cycle 7; coin_code stays 00; rupee_total unchanged.
- Double drop:
  - Stimulus: sense_r1 and sense_r2 rise together and hold 10 cycles, then drop.
  - Required: jam = 1 during hold; one coin_reject pulse on JAM exit; no coin_code.
- Jam timeout:
  - Stimulus: sense_r1 held 100 cycles.
  - Required: one 01 pulse at cycle 7; jam asserts after 64 further cycles; one coin_reject after release plus 4 low cycles.
- Saturation and reset:
  - Stimulus: 130 two-rupee coins.
  - Required: rupee_total = 255 and stays 255.
  - Then rst asserted for 1 cycle mid-DEBOUNCE: all outputs 0 the next cycle, no pulse for the interrupted coin.
